// File: rtl/yscaler_line_seq_pkg.sv
// Shared types for the vertical scaler line sequencer.
// Holds the FSM state encoding and the engine reset length.
package yscaler_line_seq_pkg;

   typedef enum logic [3:0] {
      IDLE,
      INIT,
      PRELOAD,
      SETTLE,
      STEP,
      WAIT,
      ADV,
      DRAIN,
      DONE
   } seq_state_t;

   localparam int C_INIT_CYCLES = 2;

endpackage

// File: rtl/yscaler_line_seq_if.sv
// Line-buffer request bundle: load and emit handshakes.
// The sequencer is the master, the line-buffer datapath the slave.
interface yscaler_line_seq_if;

   logic ld_req;
   logic ld_buf;
   logic ld_discard;
   logic ld_done;
   logic em_req;
   logic em_last;
   logic em_done;

   modport master (
      output ld_req,
      output ld_buf,
      output ld_discard,
      output em_req,
      output em_last,
      input  ld_done,
      input  em_done
   );

   modport slave (
      input  ld_req,
      input  ld_buf,
      input  ld_discard,
      input  em_req,
      input  em_last,
      output ld_done,
      output em_done
   );

endinterface

// File: rtl/yscaler_line_seq.sv
// Per-frame line sequencer for the vertical scaler.
// Paces the step engine and issues line load/emit requests.
module yscaler_line_seq
   import yscaler_line_seq_pkg::*;
#(
   parameter int C_RESO_WIDTH = 10
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    start,
   input  logic [C_RESO_WIDTH-1:0] ori_size,
   input  logic [C_RESO_WIDTH-1:0] scale_size,
   output logic                    sc_resetn,
   output logic                    sc_update_mul,
   output logic [C_RESO_WIDTH-1:0] sc_ori_size,
   output logic [C_RESO_WIDTH-1:0] sc_scale_size,
   input  logic                    sc_repeat_line,
   input  logic                    sc_ovalid,
   input  logic [C_RESO_WIDTH-1:0] sc_o_inv_cnt,
   yscaler_line_seq_if.master      lb,
   output logic                    busy,
   output logic                    frame_done
);

   localparam logic [C_RESO_WIDTH-1:0] ONE =
      {{(C_RESO_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [1:0] INIT_LAST =
      2'(C_INIT_CYCLES - 1);

   seq_state_t              state_q, state_d;
   logic [C_RESO_WIDTH-1:0] ori_q, ori_d;
   logic [C_RESO_WIDTH-1:0] scale_q, scale_d;
   logic [C_RESO_WIDTH-1:0] lines_ld_q, lines_ld_d;
   logic [C_RESO_WIDTH-1:0] lines_em_q, lines_em_d;
   logic [1:0]              init_q, init_d;
   logic                    ld_req_q, ld_req_d;
   logic                    ld_buf_q, ld_buf_d;
   logic                    disc_q, disc_d;
   logic                    em_req_q, em_req_d;
   logic                    last_q, last_d;

   logic do_em;
   logic do_ld;
   logic ld_fin;
   logic em_fin;

   assign do_em  = sc_ovalid && (lines_em_q < scale_q);
   assign do_ld  = !sc_repeat_line && (lines_ld_q < ori_q);
   assign ld_fin = ld_req_q && lb.ld_done;
   assign em_fin = em_req_q && lb.em_done;

   // Next-state and register-update decode for the frame FSM.
   always_comb begin
      state_d    = state_q;
      ori_d      = ori_q;
      scale_d    = scale_q;
      lines_ld_d = lines_ld_q;
      lines_em_d = lines_em_q;
      init_d     = init_q;
      ld_req_d   = ld_req_q;
      ld_buf_d   = ld_buf_q;
      disc_d     = disc_q;
      em_req_d   = em_req_q;
      last_d     = last_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               ori_d      = ori_size;
               scale_d    = scale_size;
               lines_ld_d = '0;
               lines_em_d = '0;
               init_d     = '0;
               ld_buf_d   = 1'b0;
               disc_d     = 1'b0;
               last_d     = 1'b0;
               if (ori_size == '0 ||
                   scale_size == '0)
                  state_d = DONE;
               else
                  state_d = INIT;
            end
         end
         INIT: begin
            init_d = init_q + 2'd1;
            if (init_q == INIT_LAST) begin
               ld_req_d   = 1'b1;
               ld_buf_d   = 1'b0;
               disc_d     = 1'b0;
               lines_ld_d = ONE;
               state_d    = PRELOAD;
            end
         end
         PRELOAD: begin
            if (ld_fin) begin
               ld_req_d = 1'b0;
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            state_d = STEP;
         end
         STEP: begin
            last_d = 1'b0;
            if (do_ld) begin
               ld_req_d   = 1'b1;
               ld_buf_d   = ~ld_buf_q;
               disc_d     = 1'b0;
               lines_ld_d = lines_ld_q + ONE;
            end
            if (do_em) begin
               em_req_d = 1'b1;
               last_d   = (sc_o_inv_cnt == ONE);
            end
            if (do_ld || do_em)
               state_d = WAIT;
            else
               state_d = ADV;
         end
         WAIT: begin
            if (ld_fin)
               ld_req_d = 1'b0;
            if (em_fin) begin
               em_req_d   = 1'b0;
               lines_em_d = lines_em_q + ONE;
            end
            if (!((ld_req_q && !ld_fin) ||
                  (em_req_q && !em_fin)))
               state_d = ADV;
         end
         ADV: begin
            if (last_q ||
                lines_em_q == scale_q)
               state_d = DRAIN;
            else
               state_d = SETTLE;
         end
         DRAIN: begin
            if (ld_req_q) begin
               if (lb.ld_done)
                  ld_req_d = 1'b0;
            end else if (lines_ld_q < ori_q) begin
               ld_req_d   = 1'b1;
               disc_d     = 1'b1;
               lines_ld_d = lines_ld_q + ONE;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            disc_d  = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= IDLE;
         ori_q      <= '0;
         scale_q    <= '0;
         lines_ld_q <= '0;
         lines_em_q <= '0;
         init_q     <= '0;
         ld_req_q   <= 1'b0;
         ld_buf_q   <= 1'b0;
         disc_q     <= 1'b0;
         em_req_q   <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ori_q      <= ori_d;
         scale_q    <= scale_d;
         lines_ld_q <= lines_ld_d;
         lines_em_q <= lines_em_d;
         init_q     <= init_d;
         ld_req_q   <= ld_req_d;
         ld_buf_q   <= ld_buf_d;
         disc_q     <= disc_d;
         em_req_q   <= em_req_d;
         last_q     <= last_d;
      end
   end

   // Engine is held in reset while idle and during INIT.
   assign sc_resetn     = !(state_q inside {IDLE, INIT});
   assign sc_update_mul = (state_q == ADV);
   assign sc_ori_size   = ori_q;
   assign sc_scale_size = scale_q;

   assign lb.ld_req     = ld_req_q;
   assign lb.ld_buf     = ld_buf_q;
   assign lb.ld_discard = disc_q;
   assign lb.em_req     = em_req_q;
   assign lb.em_last    = em_req_q && last_q;

   assign busy       = !(state_q inside {IDLE, DONE});
   assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_yscaler_line_seq.sv
// Bench for yscaler_line_seq with a behavioural step engine,
// a two-cycle line-buffer responder and a request scoreboard.
module tb_yscaler_line_seq;

   localparam int W = 10;

   logic         clk = 1'b0;
   logic         resetn;
   logic         start;
   logic [W-1:0] ori_size;
   logic [W-1:0] scale_size;
   logic         sc_resetn;
   logic         sc_update_mul;
   logic [W-1:0] sc_ori_size;
   logic [W-1:0] sc_scale_size;
   logic         sc_repeat_line;
   logic         sc_ovalid;
   logic [W-1:0] sc_o_inv_cnt;
   logic         busy;
   logic         frame_done;

   yscaler_line_seq_if lb();

   yscaler_line_seq #(.C_RESO_WIDTH(W)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .start          (start),
      .ori_size       (ori_size),
      .scale_size     (scale_size),
      .sc_resetn      (sc_resetn),
      .sc_update_mul  (sc_update_mul),
      .sc_ori_size    (sc_ori_size),
      .sc_scale_size  (sc_scale_size),
      .sc_repeat_line (sc_repeat_line),
      .sc_ovalid      (sc_ovalid),
      .sc_o_inv_cnt   (sc_o_inv_cnt),
      .lb             (lb),
      .busy           (busy),
      .frame_done     (frame_done)
   );

   always #5 clk = ~clk;

   // Step engine model: output j maps to input floor(j*ori/scale).
   logic [W-1:0] e_i;
   logic [W-1:0] e_o;

   function automatic int src(input int j, input int o, input int s);
      if (s == 0) return 0;
      return (j * o) / s;
   endfunction

   always @(posedge clk) begin
      if (sc_resetn !== 1'b1) begin
         e_i <= '0;
         e_o <= '0;
      end else if (sc_update_mul === 1'b1) begin
         if (sc_ovalid) e_o <= e_o + 10'd1;
         if (!sc_repeat_line) e_i <= e_i + 10'd1;
      end
   end

   always_comb begin
      int o, s, oi, ii;
      o  = int'(sc_ori_size);
      s  = int'(sc_scale_size);
      oi = int'(e_o);
      ii = int'(e_i);
      sc_ovalid      = (oi < s) && (src(oi, o, s) == ii);
      sc_repeat_line = sc_ovalid && (oi + 1 < s) &&
                       (src(oi + 1, o, s) == ii);
      sc_o_inv_cnt   = sc_scale_size - e_o;
   end

   typedef struct packed {
      logic bidx;
      logic disc;
   } ld_exp_t;

   ld_exp_t ld_q[$];
   logic    em_q[$];

   int   vectors = 0;
   int   miscompares = 0;
   int   ld_seen, em_seen, fd_cnt;
   int   ld_total_exp, em_total_exp;
   int   ld_age, em_age;
   logic ld_served, em_served;
   logic ld_prev, em_prev;
   logic overlap;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic cyc();
      ld_exp_t e;
      logic    l;
      @(negedge clk);
      if (lb.ld_req && !ld_prev) begin
         ld_seen++;
         chk("busy_on_ld", 32'(busy), 32'(1));
         if (ld_q.size() == 0) begin
            chk("ld_extra", 32'(ld_seen), 32'(ld_total_exp));
         end else begin
            e = ld_q.pop_front();
            chk("ld_buf", 32'(lb.ld_buf), 32'(e.bidx));
            chk("ld_discard", 32'(lb.ld_discard), 32'(e.disc));
         end
      end
      if (lb.em_req && !em_prev) begin
         em_seen++;
         chk("busy_on_em", 32'(busy), 32'(1));
         if (em_q.size() == 0) begin
            chk("em_extra", 32'(em_seen), 32'(em_total_exp));
         end else begin
            l = em_q.pop_front();
            chk("em_last", 32'(lb.em_last), 32'(l));
         end
      end
      if (lb.ld_req && lb.em_req) overlap = 1'b1;
      if (sc_update_mul)
         chk("upd_vs_rst", 32'(sc_resetn), 32'(1));
      if (frame_done) fd_cnt++;
      ld_prev = lb.ld_req;
      em_prev = lb.em_req;
      lb.ld_done = 1'b0;
      lb.em_done = 1'b0;
      if (!lb.ld_req) begin
         ld_age = 0;
         ld_served = 1'b0;
      end else if (!ld_served) begin
         ld_age++;
         if (ld_age == 2) begin
            lb.ld_done = 1'b1;
            ld_served = 1'b1;
         end
      end
      if (!lb.em_req) begin
         em_age = 0;
         em_served = 1'b0;
      end else if (!em_served) begin
         em_age++;
         if (em_age == 2) begin
            lb.em_done = 1'b1;
            em_served = 1'b1;
         end
      end
   endtask

   task automatic start_frame(input int o, input int s);
      int last, nd;
      ori_size   = W'(o);
      scale_size = W'(s);
      start      = 1'b1;
      ld_seen = 0;
      em_seen = 0;
      fd_cnt  = 0;
      overlap = 1'b0;
      if (o == 0 || s == 0) begin
         ld_total_exp = 0;
         em_total_exp = 0;
      end else begin
         ld_total_exp = o;
         em_total_exp = s;
         last = ((s - 1) * o) / s;
         nd = (last + 2 > o) ? o : last + 2;
         for (int k = 0; k < nd; k++)
            ld_q.push_back('{bidx: 1'(k % 2), disc: 1'b0});
         for (int k = 0; k < o - nd; k++)
            ld_q.push_back('{bidx: 1'((nd - 1) % 2), disc: 1'b1});
         for (int k = 0; k < s; k++)
            em_q.push_back(k == s - 1);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_sc_resetn"}, 32'(sc_resetn), 32'(0));
      chk({tag, "_upd"}, 32'(sc_update_mul), 32'(0));
      chk({tag, "_ld_req"}, 32'(lb.ld_req), 32'(0));
      chk({tag, "_ld_buf"}, 32'(lb.ld_buf), 32'(0));
      chk({tag, "_ld_disc"}, 32'(lb.ld_discard), 32'(0));
      chk({tag, "_em_req"}, 32'(lb.em_req), 32'(0));
      chk({tag, "_em_last"}, 32'(lb.em_last), 32'(0));
      chk({tag, "_busy"}, 32'(busy), 32'(0));
      chk({tag, "_fdone"}, 32'(frame_done), 32'(0));
      chk({tag, "_ori"}, 32'(sc_ori_size), 32'(0));
      chk({tag, "_scale"}, 32'(sc_scale_size), 32'(0));
   endtask

   task automatic run_frame(input int o, input int s,
                            input int restart_at,
                            input bit abort);
      int   n;
      logic got;
      start_frame(o, s);
      cyc();
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'(1));
      chk("sc_resetn_init0", 32'(sc_resetn), 32'(0));
      cyc();
      chk("sc_resetn_init1", 32'(sc_resetn), 32'(0));
      chk("ld_req_early", 32'(lb.ld_req), 32'(0));
      cyc();
      chk("ld_latency", 32'(lb.ld_req), 32'(1));
      chk("sc_resetn_pre", 32'(sc_resetn), 32'(1));
      chk("sc_ori_latched", 32'(sc_ori_size), 32'(o));
      chk("sc_scale_latched", 32'(sc_scale_size), 32'(s));
      n = 0;
      got = 1'b0;
      while (!got && n < 3000) begin
         if (n == restart_at) begin
            ori_size   = 10'd7;
            scale_size = 10'd1;
            start      = 1'b1;
         end else begin
            start = 1'b0;
         end
         cyc();
         n++;
         if (abort && lb.em_req) begin
            resetn = 1'b0;
            cyc();
            check_reset_outputs("abort");
            resetn = 1'b1;
            ld_q.delete();
            em_q.delete();
            cyc();
            return;
         end
         if (frame_done) got = 1'b1;
         else chk("busy_in_frame", 32'(busy), 32'(1));
      end
      start = 1'b0;
      chk("frame_done_seen", 32'(got), 32'(1));
      chk("busy_at_done", 32'(busy), 32'(0));
      chk("ld_total", 32'(ld_seen), 32'(o));
      chk("em_total", 32'(em_seen), 32'(s));
      chk("ld_q_left", 32'(ld_q.size()), 32'(0));
      chk("em_q_left", 32'(em_q.size()), 32'(0));
      chk("sc_ori_kept", 32'(sc_ori_size), 32'(o));
      cyc();
      chk("frame_done_pulse", 32'(frame_done), 32'(0));
      chk("busy_idle", 32'(busy), 32'(0));
      cyc();
      cyc();
      chk("fd_count", 32'(fd_cnt), 32'(1));
   endtask

   initial begin
      resetn     = 1'b0;
      start      = 1'b0;
      ori_size   = '0;
      scale_size = '0;
      lb.ld_done = 1'b0;
      lb.em_done = 1'b0;
      ld_prev    = 1'b0;
      em_prev    = 1'b0;
      ld_age     = 0;
      em_age     = 0;
      ld_served  = 1'b0;
      em_served  = 1'b0;
      ld_seen    = 0;
      em_seen    = 0;
      fd_cnt     = 0;
      overlap    = 1'b0;
      ld_total_exp = 0;
      em_total_exp = 0;
      cyc();
      cyc();
      check_reset_outputs("reset");
      resetn = 1'b1;
      cyc();

      run_frame(2, 4, -1, 1'b0);
      run_frame(4, 2, -1, 1'b0);
      run_frame(5, 2, -1, 1'b0);
      run_frame(3, 3, 5, 1'b0);
      chk("overlap_3x3", 32'(overlap), 32'(1));

      start_frame(3, 0);
      cyc();
      start = 1'b0;
      chk("zero_fdone", 32'(frame_done), 32'(1));
      chk("zero_busy", 32'(busy), 32'(0));
      chk("zero_ld_req", 32'(lb.ld_req), 32'(0));
      cyc();
      chk("zero_fdone_pulse", 32'(frame_done), 32'(0));
      for (int k = 0; k < 6; k++) cyc();
      chk("zero_ld_cnt", 32'(ld_seen), 32'(0));
      chk("zero_em_cnt", 32'(em_seen), 32'(0));
      chk("zero_fd_cnt", 32'(fd_cnt), 32'(1));
      chk("zero_busy_end", 32'(busy), 32'(0));

      run_frame(2, 4, -1, 1'b1);
      run_frame(2, 4, -1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
